// File: rtl/ocm_arbiter.sv
// Two-requester round-robin arbiter for a single on-chip memory port.
// A grant is held until the owner signals done or a hold watchdog expires.
module ocm_arbiter #(
  parameter int ADDR_BITS = 12,
  parameter int MAX_HOLD  = 16
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 i_req0,
  input  logic                 i_req1,
  input  logic                 i_done0,
  input  logic                 i_done1,
  input  logic [ADDR_BITS-1:0] i_addr0,
  input  logic [ADDR_BITS-1:0] i_addr1,
  input  logic [31:0]          i_data0,
  input  logic [31:0]          i_data1,
  input  logic [3:0]           i_dm_write0,
  input  logic [3:0]           i_dm_write1,
  output logic                 o_grant0,
  output logic                 o_grant1,
  output logic [ADDR_BITS-1:0] o_ocm_addr,
  output logic [31:0]          o_ocm_data,
  output logic [3:0]           o_ocm_dm_write,
  output logic                 o_timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  localparam logic [4:0] HOLD_LAST = 5'(MAX_HOLD - 1);

  state_e     state_q, state_d;
  logic       ptr_q, ptr_d;        // 0: requester 0 wins a tie, 1: requester 1
  logic [4:0] hold_q, hold_d;
  logic       timeout_q, timeout_d;

  logic owner, own_req, own_done, oth_req, expire;
  state_e own_state, oth_state;

  // NOTE: every variable driven here gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    timeout_d = timeout_q;

    owner     = (state_q == OWN1);
    own_req   = owner ? i_req1  : i_req0;
    own_done  = owner ? i_done1 : i_done0;
    oth_req   = owner ? i_req0  : i_req1;
    expire    = (hold_q == HOLD_LAST);
    own_state = owner ? OWN1 : OWN0;
    oth_state = owner ? OWN0 : OWN1;

    case (state_q)
      IDLE: begin
        hold_d = 5'd0;
        if (i_req0 && i_req1) state_d = ptr_q ? OWN1 : OWN0;
        else if (i_req0)      state_d = OWN0;
        else if (i_req1)      state_d = OWN1;
      end
      OWN0, OWN1: begin
        if (own_done || expire) begin
          // A done arriving on the expiry cycle is a normal release.
          ptr_d  = ~owner;
          hold_d = 5'd0;
          if (!own_done) timeout_d = 1'b1;
          if (oth_req)      state_d = oth_state;
          else if (own_req) state_d = own_state;
          else              state_d = IDLE;
        end else begin
          hold_d = hold_q + 5'd1;
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = 5'd0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      ptr_q     <= 1'b0;
      hold_q    <= 5'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_grant0  = (state_q == OWN0);
  assign o_grant1  = (state_q == OWN1);
  assign o_timeout = timeout_q;

  // Outputs decode straight from the state register, so async reset zeroes
  // the write enables without waiting for a clock edge.
  always_comb begin
    o_ocm_addr     = '0;
    o_ocm_data     = '0;
    o_ocm_dm_write = '0;
    case (state_q)
      OWN0: begin
        o_ocm_addr     = i_addr0;
        o_ocm_data     = i_data0;
        o_ocm_dm_write = i_dm_write0;
      end
      OWN1: begin
        o_ocm_addr     = i_addr1;
        o_ocm_data     = i_data1;
        o_ocm_dm_write = i_dm_write1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/ocm_arbiter.md
OCM_ARBITER -- requirements
Module: ocm_arbiter

Interface
REQ-001: Parameter ADDR_BITS, default 12, width of on-chip memory (OCM) word address.
REQ-002: Parameter MAX_HOLD, default 16, maximum cycles one grant may be held; legal range 2..31.
REQ-003: clk  input  1  single clock; all state updates on the rising edge.
REQ-004: nrst  input  1  reset, asynchronous, active-low.
REQ-005: i_req0 / i_req1  input  1  memory-access request from core-side memory stage 0 / 1.
REQ-006: i_done0 / i_done1  input  1  one-cycle pulse from requester: transaction complete, grant may be released.
REQ-007: i_addr0 / i_addr1  input  ADDR_BITS  OCM address from requester 0 / 1.
REQ-008: i_data0 / i_data1  input  32  write data from requester 0 / 1.
REQ-009: i_dm_write0 / i_dm_write1  input  4  byte write enables from requester 0 / 1.
REQ-010: o_grant0 / o_grant1  output  1  requester 0 / 1 owns the OCM port.
REQ-011: o_ocm_addr  output  ADDR_BITS  address to OCM.
REQ-012: o_ocm_data  output  32  write data to OCM.
REQ-013: o_ocm_dm_write  output  4  byte write enables to OCM.
REQ-014: o_timeout  output  1  sticky flag: a grant was revoked by the watchdog.

Function
REQ-015: The block SHALL implement an FSM with states IDLE, OWN0, OWN1; o_grant0 = (state==OWN0), o_grant1 = (state==OWN1), both registered.
REQ-016: The two grants SHALL never be high in the same cycle.
REQ-017: From IDLE, with any request high, next state SHALL be OWN of the winner; both requesting -> winner is the requester indicated by the priority pointer; none -> stay IDLE.
REQ-018: Grant latency SHALL be exactly one cycle: request sampled high in IDLE at edge N -> grant high after edge N.
REQ-019: In OWNx, the grant SHALL be held regardless of i_reqx until i_donex is sampled high or the watchdog fires.
REQ-020: On release of OWNx: if the other requester's i_req is high, next state SHALL be OWN(other) (direct hand-off, no IDLE cycle); else if i_reqx is high, next state SHALL be OWNx; else IDLE.
REQ-021: The priority pointer SHALL be set to the other requester on every release of OWNx (round-robin).
REQ-022: i_done of the requester not currently owning the port SHALL be ignored.
REQ-023: A 5-bit hold counter SHALL clear on entry to any OWN state and increment each cycle in OWN; when it equals MAX_HOLD-1 without i_done, the grant SHALL be released per REQ-020 and o_timeout SHALL set.
REQ-024: o_timeout SHALL stay high until reset.
REQ-025: Data-path mux SHALL be combinational from state: OWNx -> o_ocm_addr/o_ocm_data/o_ocm_dm_write = i_addrx/i_datax/i_dm_writex.
REQ-026: In IDLE, o_ocm_addr, o_ocm_data and o_ocm_dm_write SHALL be 0 (no spurious writes).
REQ-027: i_done and watchdog expiry in the same cycle SHALL count as a normal release; o_timeout SHALL NOT set.

Reset
REQ-028: nrst low SHALL immediately force: state IDLE, both grants 0, pointer = requester 0, hold counter 0, o_timeout 0, OCM outputs 0.
REQ-029: Reset asserted mid-grant SHALL abort the grant with no write-enable glitch after reset assertion; after release the block SHALL restart from IDLE.

Verification
REQ-030: Single request: i_req0=1 from IDLE -> o_grant0=1 next cycle, o_ocm_addr=i_addr0=0x123; i_done0 pulse with i_req0=0 -> IDLE, outputs 0.
REQ-031: Simultaneous: i_req0=i_req1=1 after reset -> OWN0; i_done0 -> OWN1 with no IDLE cycle; i_done1 with both still requesting -> OWN0.
REQ-032: Watchdog: i_req1=1, never done, MAX_HOLD=16 -> grant1 high exactly 16 cycles, then released, o_timeout=1 and remains 1.
REQ-033: Foreign done: OWN0 held, i_done1 pulsed -> no state change, o_grant0 stays 1.
REQ-034: Async reset mid-OWN1 with i_dm_write1=4'b1111 -> o_grant1=0 and o_ocm_dm_write=0 without waiting for clk edge.
REQ-035: Idle safety: no requests, random i_addr/i_data/i_dm_write -> o_ocm_dm_write stays 0 for 100 cycles.
